// File: rtl/rgb_fade_sequencer.sv
// Breathing red/green/blue/white sequencer for the SB_RGBA_DRV RGB driver.
// Each colour fades up, holds at full brightness, then fades down.
`timescale 1ns/1ps
module rgb_fade_sequencer #(
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 46875,
    parameter int HOLD_STEPS = 64
) (
    input  logic clk_12Mhz,
    input  logic rst,
    input  logic seq_enable,
    output logic pwm_red,
    output logic pwm_green,
    output logic pwm_blue,
    output logic led_en,
    output logic busy,
    output logic cycle_done
);

    localparam int PRE_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [PWM_BITS-1:0] DMAX      = '1;
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FADE_UP,
        HOLD,
        FADE_DOWN
    } state_t;

    state_t              state;
    logic [PRE_W-1:0]    prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [1:0]          colour;
    logic [2:0]          mask;
    logic                step_tick;

    // Prescaler sits at 0 in IDLE, so a tick can only happen while running.
    assign step_tick = (state != IDLE) && (prescaler == PRE_LAST);

    always_comb begin
        mask = 3'b000;
        unique case (colour)
            2'd0: mask = 3'b001;
            2'd1: mask = 3'b010;
            2'd2: mask = 3'b100;
            2'd3: mask = 3'b111;
        endcase
    end

    always_ff @(posedge clk_12Mhz or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_12Mhz or posedge rst) begin
        if (rst) begin
            pwm_red   <= 1'b0;
            pwm_green <= 1'b0;
            pwm_blue  <= 1'b0;
        end else begin
            pwm_red   <= mask[0] && (pwm_cnt < duty);
            pwm_green <= mask[1] && (pwm_cnt < duty);
            pwm_blue  <= mask[2] && (pwm_cnt < duty);
        end
    end

    always_ff @(posedge clk_12Mhz or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            prescaler  <= '0;
            duty       <= '0;
            hold_cnt   <= '0;
            colour     <= '0;
            busy       <= 1'b0;
            led_en     <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            if (state == IDLE) begin
                prescaler <= '0;
                if (seq_enable) begin
                    state    <= FADE_UP;
                    duty     <= '0;
                    hold_cnt <= '0;
                    colour   <= '0;
                    busy     <= 1'b1;
                    led_en   <= 1'b1;
                end
            end else if (!seq_enable) begin
                // Disable beats a coincident tick: no fade-out, no advance.
                state     <= IDLE;
                prescaler <= '0;
                duty      <= '0;
                hold_cnt  <= '0;
                colour    <= '0;
                busy      <= 1'b0;
                led_en    <= 1'b0;
            end else begin
                prescaler <= step_tick ? '0 : prescaler + 1'b1;
                if (step_tick) begin
                    unique case (state)
                        FADE_UP: begin
                            if (duty == DMAX) begin
                                state    <= HOLD;
                                hold_cnt <= '0;
                            end else begin
                                duty <= duty + 1'b1;
                            end
                        end
                        HOLD: begin
                            if (hold_cnt == HOLD_LAST) begin
                                state <= FADE_DOWN;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                        FADE_DOWN: begin
                            if (duty == '0) begin
                                state      <= FADE_UP;
                                colour     <= colour + 1'b1;
                                cycle_done <= (colour == 2'd3);
                            end else begin
                                duty <= duty - 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: closed-form reference model feeding a
// scoreboard queue, plus window-count tables and hand-written corner runs.
`timescale 1ns/1ps
module tb_rgb_fade_sequencer;

    localparam int PB   = 3;
    localparam int STEP = 4;
    localparam int HS   = 2;
    localparam int DM   = (1 << PB) - 1;
    localparam int PER  = 2 * (DM + 1) + HS;

    logic clk_12Mhz;
    logic rst;
    logic seq_enable;
    logic pwm_red;
    logic pwm_green;
    logic pwm_blue;
    logic led_en;
    logic busy;
    logic cycle_done;

    rgb_fade_sequencer #(
        .PWM_BITS  (PB),
        .STEP_DIV  (STEP),
        .HOLD_STEPS(HS)
    ) dut (
        .clk_12Mhz (clk_12Mhz),
        .rst       (rst),
        .seq_enable(seq_enable),
        .pwm_red   (pwm_red),
        .pwm_green (pwm_green),
        .pwm_blue  (pwm_blue),
        .led_en    (led_en),
        .busy      (busy),
        .cycle_done(cycle_done)
    );

    initial clk_12Mhz = 1'b0;
    always #5 clk_12Mhz = ~clk_12Mhz;

    // bit order: {cycle_done, busy, led_en, blue, green, red}
    typedef struct packed {
        logic done;
        logic busy;
        logic led;
        logic blue;
        logic green;
        logic red;
    } outs_t;

    typedef struct {
        int start;
        int len;
        int red;
        int green;
        int blue;
        int done;
    } win_t;

    outs_t      sb[$];
    logic [5:0] log_v [0:511];
    win_t       tbl [5];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit m_active = 0;
    int m_n      = 0;
    int m_cnt    = 0;

    function automatic logic [5:0] sample();
        return {cycle_done, busy, led_en, pwm_blue, pwm_green, pwm_red};
    endfunction

    function automatic int duty_of(int n);
        int p;
        p = (n / STEP) % PER;
        if (p <= DM) return p;
        if (p <= DM + HS) return DM;
        return PER - 1 - p;
    endfunction

    function automatic logic [2:0] mask_of(int n);
        case ((n / STEP / PER) % 4)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b111;
        endcase
    endfunction

    function automatic int count_bit(int b, int from, int to);
        int s;
        s = 0;
        for (int i = from; i <= to; i++) s += int'(log_v[i][b]);
        return s;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic en);
        outs_t      e;
        outs_t      want;
        logic [2:0] mk;
        logic [5:0] got;
        bit         hi;
        seq_enable = en;
        e = '0;
        if (m_active) begin
            mk      = mask_of(m_n);
            hi      = m_cnt < duty_of(m_n);
            e.red   = mk[0] && hi;
            e.green = mk[1] && hi;
            e.blue  = mk[2] && hi;
            e.done  = en && (m_n % STEP == STEP - 1) &&
                      (((m_n + 1) / STEP) % (4 * PER) == 0);
        end
        if (m_active && en) begin
            m_n++;
        end else if (m_active) begin
            m_active = 0;
        end else if (en) begin
            m_active = 1;
            m_n = 0;
        end
        e.busy = m_active;
        e.led  = m_active;
        m_cnt  = (m_cnt + 1) % (DM + 1);
        sb.push_back(e);
        @(posedge clk_12Mhz);
        @(negedge clk_12Mhz);
        cyc++;
        got = sample();
        log_v[cyc] = got;
        want = sb.pop_front();
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL scoreboard cycle %0d: got %b, expected %b",
                     cyc, got, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seq_enable = 1'b0;
        repeat (2) @(negedge clk_12Mhz);
        chk("reset_outputs", int'(sample()), 0);
        rst = 1'b0;
        cyc = 0;
        m_active = 0;
        m_n = 0;
        m_cnt = 0;
        log_v[0] = sample();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 72-cycle colour windows of registered PWM output after start.
        tbl[0] = '{start:  2, len: 72, red: 35, green:  0, blue:  0, done: 0};
        tbl[1] = '{start: 74, len: 72, red:  0, green: 35, blue:  0, done: 0};
        tbl[2] = '{start:146, len: 72, red:  0, green:  0, blue: 35, done: 0};
        tbl[3] = '{start:218, len: 72, red: 35, green: 35, blue: 35, done: 1};
        tbl[4] = '{start:290, len: 72, red: 35, green:  0, blue:  0, done: 0};

        rst = 1'b1;
        seq_enable = 1'b0;

        // Full sequence from reset.
        do_reset();
        for (int i = 0; i < 362; i++) step(1'b1);
        chk("busy_cycle0", int'(log_v[0][4]), 0);
        chk("busy_cycle1", int'(log_v[1][4]), 1);
        chk("led_en_cycle1", int'(log_v[1][3]), 1);
        chk("hold_red_high_of_8", count_bit(0, 30, 37), 7);
        chk("duty3_red_high_of_8",
            count_bit(0, 14, 17) + count_bit(0, 58, 61), 3);
        chk("cycle_done_at_289", int'(log_v[289][5]), 1);
        chk("cycle_done_total", count_bit(5, 1, 362), 1);
        for (int j = 0; j < 5; j++) begin
            int a;
            int b;
            a = tbl[j].start;
            b = tbl[j].start + tbl[j].len - 1;
            chk($sformatf("win%0d_red", j),   count_bit(0, a, b), tbl[j].red);
            chk($sformatf("win%0d_green", j), count_bit(1, a, b), tbl[j].green);
            chk($sformatf("win%0d_blue", j),  count_bit(2, a, b), tbl[j].blue);
            chk($sformatf("win%0d_done", j),  count_bit(5, a, b), tbl[j].done);
        end

        // Disable at duty 5 in green fade-down, then re-enable.
        do_reset();
        for (int i = 0; i < 122; i++) step(1'b1);
        step(1'b0);
        chk("disable_busy", int'(log_v[123][4]), 0);
        chk("disable_led_en", int'(log_v[123][3]), 0);
        step(1'b0);
        chk("disable_pwm_off", int'(log_v[124][2:0]), 0);
        for (int i = 0; i < 80; i++) step(1'b1);
        chk("reenable_red", count_bit(0, 126, 197), 35);
        chk("reenable_green", count_bit(1, 125, 204), 0);
        chk("reenable_blue", count_bit(2, 125, 204), 0);

        // Asynchronous reset while holding at full brightness.
        do_reset();
        for (int i = 0; i < 36; i++) step(1'b1);
        chk("hold_led_en_before_rst", int'(led_en), 1);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", int'(sample()), 0);
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1);
        chk("restart_red_quiet", count_bit(0, 1, 8), 0);
        chk("restart_first_tick", int'(log_v[9][0]), 1);

        // Disable in the same cycle as the white-phase wrap tick.
        do_reset();
        for (int i = 0; i < 288; i++) step(1'b1);
        step(1'b0);
        chk("coincident_no_done", int'(log_v[289][5]), 0);
        chk("coincident_busy", int'(log_v[289][4]), 0);
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int i = 0; i < 10; i++) step(1'b1);
        chk("coincident_done_total", count_bit(5, 1, cyc), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
